ddl_packet_decoder: RTL and testbench

DDL_PACKET_DECODER -- requirements
Module: ddl_packet_decoder

---
 rtl/ddl_packet_decoder.sv | 197 +++++++++++++++++++
 tb/tb_ddl_packet_decoder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddl_packet_decoder.sv
// DDL link packet decoder: splits rx_dv-delimited frames into command
// words (req/ack handshake) and data payload words (FIFO write side).
//
// Ports:
//   ddl_usrclk, reset      - clock, async active-high reset
//   rxdata, rx_dv, rx_er   - received link word, frame-body flag, link error
//   wr_en, din             - payload FIFO write (1 cycle after the rx word)
//   full, prog_full        - payload FIFO status
//   ddl_cmd, ddl_cmd_req   - decoded 32-bit command, held until acknowledged
//   ddl_cmd_ack            - command consumer acknowledge
//   ddl_xoff               - prog_full delayed by one cycle
//   frame_done, frame_err  - one-cycle status pulses
//   err_cnt                - saturating error counter
module ddl_packet_decoder #(
    parameter logic [3:0]  CMD_TYPE  = 4'h1,
    parameter logic [3:0]  DATA_TYPE = 4'h2,
    parameter logic [11:0] MAX_LEN   = 12'd2048
) (
    input  logic        ddl_usrclk,
    input  logic        reset,
    input  logic [15:0] rxdata,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic        wr_en,
    output logic [15:0] din,
    input  logic        full,
    input  logic        prog_full,
    output logic [31:0] ddl_cmd,
    output logic        ddl_cmd_req,
    input  logic        ddl_cmd_ack,
    output logic        ddl_xoff,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_LO,
        S_CMD_HI,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_cnt;
    logic [11:0] w_cnt_nxt;
    logic        r_ferr;
    logic        w_ferr_nxt;
    logic        r_armed;
    logic [15:0] r_cmd_lo;

    logic        w_err;
    logic        w_wr;
    logic        w_done;
    logic        w_cap_lo;
    logic        w_cmd_ld;

    logic [3:0]  w_hdr_type;
    logic [11:0] w_hdr_len;
    logic        w_len_ok;
    logic        w_cmd_free;

    assign w_hdr_type = rxdata[15:12];
    assign w_hdr_len  = rxdata[11:0];
    assign w_len_ok   = (w_hdr_len != 12'd0) && (w_hdr_len <= MAX_LEN);
    // A new command may load when the slot is empty or being freed now.
    assign w_cmd_free = !ddl_cmd_req || ddl_cmd_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ferr_nxt  = r_ferr;
        w_err       = 1'b0;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        w_cap_lo    = 1'b0;
        w_cmd_ld    = 1'b0;
        if (!r_armed) begin
            // After reset we may be mid-frame: wait for a gap first.
            w_state_nxt = S_IDLE;
        end else if (rx_er) begin
            w_err       = 1'b1;
            w_state_nxt = rx_dv ? S_DRAIN : S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (rx_dv) begin
                        if (w_hdr_type == CMD_TYPE) begin
                            w_state_nxt = S_CMD_LO;
                        end else if (w_hdr_type == DATA_TYPE && w_len_ok) begin
                            w_state_nxt = S_DATA;
                            w_cnt_nxt   = w_hdr_len;
                            w_ferr_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = S_DRAIN;
                            w_err       = 1'b1;
                        end
                    end
                end
                S_CMD_LO: begin
                    if (rx_dv) begin
                        w_cap_lo    = 1'b1;
                        w_state_nxt = S_CMD_HI;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err       = 1'b1;
                    end
                end
                S_CMD_HI: begin
                    if (rx_dv) begin
                        w_state_nxt = S_DRAIN;
                        if (w_cmd_free) begin
                            w_cmd_ld = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err       = 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_dv) begin
                        w_cnt_nxt = r_cnt - 12'd1;
                        if (full) begin
                            w_err      = 1'b1;
                            w_ferr_nxt = 1'b1;
                        end else begin
                            w_wr = 1'b1;
                        end
                        if (r_cnt == 12'd1) begin
                            w_state_nxt = S_DRAIN;
                            w_done      = !(r_ferr || full);
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err       = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!rx_dv) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ddl_usrclk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 12'd0;
            r_ferr      <= 1'b0;
            r_armed     <= 1'b0;
            r_cmd_lo    <= 16'd0;
            wr_en       <= 1'b0;
            din         <= 16'd0;
            ddl_cmd     <= 32'd0;
            ddl_cmd_req <= 1'b0;
            ddl_xoff    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ferr     <= w_ferr_nxt;
            r_armed    <= r_armed | ~rx_dv;
            wr_en      <= w_wr;
            ddl_xoff   <= prog_full;
            frame_done <= w_done;
            frame_err  <= w_err;
            if (w_wr) begin
                din <= rxdata;
            end
            if (w_cap_lo) begin
                r_cmd_lo <= rxdata;
            end
            // A load on the ack cycle keeps req high with the new command.
            if (w_cmd_ld) begin
                ddl_cmd     <= {rxdata, r_cmd_lo};
                ddl_cmd_req <= 1'b1;
            end else if (ddl_cmd_ack) begin
                ddl_cmd_req <= 1'b0;
            end
            if (w_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddl_packet_decoder.sv
// Self-checking bench for ddl_packet_decoder: directed frames plus
// randomized traffic against a frame-position reference model.
module tb_ddl_packet_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rxdata;
    logic        rx_dv;
    logic        rx_er;
    logic        wr_en;
    logic [15:0] din;
    logic        full;
    logic        prog_full;
    logic [31:0] ddl_cmd;
    logic        ddl_cmd_req;
    logic        ddl_cmd_ack;
    logic        ddl_xoff;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    ddl_packet_decoder dut (
        .ddl_usrclk  (clk),
        .reset       (rst),
        .rxdata      (rxdata),
        .rx_dv       (rx_dv),
        .rx_er       (rx_er),
        .wr_en       (wr_en),
        .din         (din),
        .full        (full),
        .prog_full   (prog_full),
        .ddl_cmd     (ddl_cmd),
        .ddl_cmd_req (ddl_cmd_req),
        .ddl_cmd_ack (ddl_cmd_ack),
        .ddl_xoff    (ddl_xoff),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt)
    );

    localparam int MAXL = 2048;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: position of the current word in its rx_dv run
    int          m_pos;
    bit          m_dead;
    bit          m_ferr;
    bit          m_armed;
    bit [3:0]    m_type;
    int          m_len;
    bit [15:0]   m_lo;

    bit          e_wr;
    bit [15:0]   e_din;
    bit [31:0]   e_cmd;
    bit          e_req;
    bit          e_xoff;
    bit          e_done;
    bit          e_err;
    bit [7:0]    e_cnt;

    bit [15:0]   obs[$];
    int          done_cnt;
    int          fe_cnt;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit err;
        bit ld;
        err    = 0;
        ld     = 0;
        e_wr   = 0;
        e_done = 0;
        if (rst) begin
            m_armed = 0; m_pos = 0; m_dead = 0; m_ferr = 0;
            e_din = 0; e_cmd = 0; e_req = 0; e_xoff = 0;
            e_err = 0; e_cnt = 0;
            return;
        end
        e_xoff = prog_full;
        if (!m_armed) begin
            if (!rx_dv) m_armed = 1;
        end else if (rx_er) begin
            err = 1;
            if (rx_dv) begin
                m_dead = 1;
                m_pos++;
            end
        end else if (rx_dv) begin
            if (m_pos == 0) begin
                m_type = rxdata[15:12];
                m_len  = int'(rxdata[11:0]);
                m_ferr = 0;
                m_dead = 0;
                if (!(m_type == 4'h1 ||
                      (m_type == 4'h2 && m_len >= 1 && m_len <= MAXL))) begin
                    err    = 1;
                    m_dead = 1;
                end
            end else if (!m_dead) begin
                if (m_type == 4'h1) begin
                    if (m_pos == 1) begin
                        m_lo = rxdata;
                    end else begin
                        if (!e_req || ddl_cmd_ack) begin
                            ld    = 1;
                            e_cmd = {rxdata, m_lo};
                        end else begin
                            err = 1;
                        end
                        m_dead = 1;
                    end
                end else begin
                    if (full) begin
                        err    = 1;
                        m_ferr = 1;
                    end else begin
                        e_wr  = 1;
                        e_din = rxdata;
                    end
                    if (m_pos == m_len) begin
                        e_done = !m_ferr;
                        m_dead = 1;
                    end
                end
            end
            m_pos++;
        end else begin
            if (m_pos > 0 && !m_dead) err = 1;
        end
        if (!rx_dv) begin
            m_pos  = 0;
            m_dead = 0;
        end
        if (ld) e_req = 1;
        else if (e_req && ddl_cmd_ack) e_req = 0;
        e_err = err;
        if (err && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
    endtask

    // One clock: model the inputs, clock the DUT, compare all outputs.
    task automatic cycle();
        prog_full = 1'($urandom_range(0, 1));
        model_step();
        @(posedge clk);
        #1;
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        chk("din", 32'(din), 32'(e_din));
        chk("ddl_cmd", ddl_cmd, e_cmd);
        chk("ddl_cmd_req", 32'(ddl_cmd_req), 32'(e_req));
        chk("ddl_xoff", 32'(ddl_xoff), 32'(e_xoff));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("frame_err", 32'(frame_err), 32'(e_err));
        chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
        if (wr_en === 1'b1) obs.push_back(din);
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    endtask

    task automatic word(input logic [15:0] d, input logic er = 1'b0);
        rx_dv  = 1'b1;
        rx_er  = er;
        rxdata = d;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_dv  = 1'b0;
            rx_er  = 1'b0;
            rxdata = 16'($urandom);
            cycle();
        end
    endtask

    task automatic clr();
        obs.delete();
        done_cnt = 0;
        fe_cnt   = 0;
    endtask

    task automatic rword(input logic [15:0] d);
        full        = ($urandom_range(0, 6) == 0);
        ddl_cmd_ack = ($urandom_range(0, 4) == 0);
        word(d, ($urandom_range(0, 40) == 0));
    endtask

    task automatic rand_frame();
        int          kind;
        int          len;
        int          body;
        logic [3:0]  t;
        logic [15:0] hdr;
        kind = $urandom_range(0, 9);
        if (kind <= 4) begin
            len  = $urandom_range(1, 8);
            hdr  = {4'h2, 12'(len)};
            body = len;
            if ($urandom_range(0, 4) == 0) body = $urandom_range(0, len + 2);
        end else if (kind <= 7) begin
            hdr  = {4'h1, 12'($urandom)};
            body = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 2;
        end else if (kind == 8) begin
            t = 4'($urandom);
            if (t == 4'h1 || t == 4'h2) t = 4'hF;
            hdr  = {t, 12'($urandom)};
            body = $urandom_range(0, 3);
        end else begin
            hdr  = ($urandom_range(0, 1) == 0) ? 16'h2000 : 16'h2FFF;
            body = $urandom_range(0, 3);
        end
        rword(hdr);
        for (int i = 0; i < body; i++) rword(16'($urandom));
        full = 1'b0;
        for (int i = 0; i < $urandom_range(1, 3); i++) begin
            ddl_cmd_ack = ($urandom_range(0, 3) == 0);
            idle(1);
        end
        ddl_cmd_ack = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; rx_dv = 0; rx_er = 0; rxdata = 0;
        full = 0; prog_full = 0; ddl_cmd_ack = 0;
        cycle();
        cycle();
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_req", 32'(ddl_cmd_req), 32'd0);
        chk("reset_cmd", ddl_cmd, 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        idle(2);

        // basic data frame
        clr();
        word(16'h2003); word(16'hA001); word(16'hA002); word(16'hA003);
        idle(2);
        chk("d3_nwr", obs.size(), 32'd3);
        if (obs.size() == 3) begin
            chk("d3_w0", 32'(obs[0]), 32'h0000A001);
            chk("d3_w1", 32'(obs[1]), 32'h0000A002);
            chk("d3_w2", 32'(obs[2]), 32'h0000A003);
        end
        chk("d3_done", done_cnt, 32'd1);
        chk("d3_errcnt", 32'(err_cnt), 32'd0);

        // command held until ack
        word(16'h1000); word(16'h0014); word(16'h0000);
        idle(5);
        chk("cmd_val", ddl_cmd, 32'h00000014);
        chk("cmd_req_held", 32'(ddl_cmd_req), 32'd1);
        ddl_cmd_ack = 1'b1;
        idle(1);
        ddl_cmd_ack = 1'b0;
        chk("cmd_req_fall", 32'(ddl_cmd_req), 32'd0);

        // second command while pending: drop, then ack-same-cycle load
        word(16'h1000); word(16'h0014); word(16'h0000);
        idle(1);
        base = int'(err_cnt);
        word(16'h1000); word(16'h0015); word(16'h0000);
        idle(1);
        chk("drop_cmd", ddl_cmd, 32'h00000014);
        chk("drop_errcnt", 32'(err_cnt), 32'(base + 1));
        word(16'h1000); word(16'h0015);
        ddl_cmd_ack = 1'b1;
        word(16'h0000);
        ddl_cmd_ack = 1'b0;
        idle(1);
        chk("reload_req", 32'(ddl_cmd_req), 32'd1);
        chk("reload_cmd", ddl_cmd, 32'h00000015);
        ddl_cmd_ack = 1'b1;
        idle(1);
        ddl_cmd_ack = 1'b0;

        // truncated data frame, then a good one
        clr();
        base = int'(err_cnt);
        word(16'h2004); word(16'hB001); word(16'hB002);
        idle(1);
        chk("trunc_nwr", obs.size(), 32'd2);
        chk("trunc_done", done_cnt, 32'd0);
        chk("trunc_ferr", fe_cnt, 32'd1);
        chk("trunc_errcnt", 32'(err_cnt), 32'(base + 1));
        word(16'h2002); word(16'hC001); word(16'hC002);
        idle(1);
        chk("after_trunc_done", done_cnt, 32'd1);

        // full on the middle word
        clr();
        base = int'(err_cnt);
        word(16'h2003); word(16'hD001);
        full = 1'b1; word(16'hD002); full = 1'b0;
        word(16'hD003);
        idle(1);
        chk("full_nwr", obs.size(), 32'd2);
        if (obs.size() == 2) chk("full_w1", 32'(obs[1]), 32'h0000D003);
        chk("full_done", done_cnt, 32'd0);
        chk("full_errcnt", 32'(err_cnt), 32'(base + 1));

        // rx_er mid-frame
        clr();
        base = int'(err_cnt);
        word(16'h2004); word(16'hE001); word(16'hE002, 1'b1);
        word(16'hE003); word(16'hE004);
        idle(1);
        chk("rxer_nwr", obs.size(), 32'd1);
        chk("rxer_errcnt", 32'(err_cnt), 32'(base + 1));

        // length boundaries
        clr();
        base = int'(err_cnt);
        word(16'h2000); word(16'h1111); idle(1);
        word(16'h2801); word(16'h2222); idle(1);
        chk("len_bad_errcnt", 32'(err_cnt), 32'(base + 2));
        chk("len_bad_nwr", obs.size(), 32'd0);
        word(16'h2800);
        for (int i = 0; i < MAXL; i++) word(16'(i));
        idle(1);
        chk("maxlen_nwr", obs.size(), 32'(MAXL));
        chk("maxlen_done", done_cnt, 32'd1);

        // randomized traffic
        for (int f = 0; f < 400; f++) rand_frame();

        // reset mid data frame, released while rx_dv stays high
        word(16'h2006); word(16'hF001); word(16'hF002);
        clr();
        rst = 1'b1;
        word(16'hF003);
        word(16'hF004);
        rst = 1'b0;
        word(16'hF005); word(16'hF006);
        idle(1);
        chk("rst_nwr", obs.size(), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        chk("rst_cmd", ddl_cmd, 32'd0);
        word(16'h2001); word(16'h5A5A);
        idle(1);
        chk("post_rst_nwr", obs.size(), 32'd1);
        chk("post_rst_done", done_cnt, 32'd1);

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            word(16'hF000);
            idle(1);
        end
        chk("sat_errcnt", 32'(err_cnt), 32'h000000FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
